// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM function module: pin command encodings,
// call bit positions, mode register value, timing defaults and FSM states.
package sdram_pkg;

    localparam int CNT_W = 14;

    // {NRAS, NCAS, NWE}
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_AREF  = 3'b001;
    localparam logic [2:0] CMD_LMR   = 3'b000;

    localparam int CALL_WRITE   = 3;
    localparam int CALL_READ    = 2;
    localparam int CALL_REFRESH = 1;
    localparam int CALL_INIT    = 0;

    // CL=3, sequential burst, BL=1
    localparam logic [12:0] MODE_REG = 13'h030;
    // A10 high selects all banks for PRE and auto-precharge for READ/WRITE
    localparam logic [12:0] A10_ALL  = 13'h0400;

    localparam int TINIT_DEF = 13300;
    localparam int TRP_DEF   = 3;
    localparam int TRRC_DEF  = 9;
    localparam int TRCD_DEF  = 3;
    localparam int CL_DEF    = 3;
    localparam int TWR_DEF   = 2;
    localparam int TMRD_DEF  = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_WAIT,
        ST_PRE,
        ST_AREF1,
        ST_AREF2,
        ST_LMR,
        ST_ACT,
        ST_RW,
        ST_WAIT,
        ST_DONE,
        ST_DONE_WAIT
    } state_e;

endpackage

// File: rtl/sdram_wait_counter.sv
// Loadable down-counter that times each step of an SDRAM sequence.
// A loaded value N makes expire high in the Nth cycle after the load.
module sdram_wait_counter
    import sdram_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and rest at 1
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sdram_funcmod.sv
// Responder side of the SDRAM call/done handshake. Each FSM state issues its
// command in its first cycle (NOP afterwards) and stays for the number of
// cycles loaded into the wait counter on entry.
module sdram_funcmod
    import sdram_pkg::*;
#(
    parameter int TINIT = TINIT_DEF,
    parameter int TRP   = TRP_DEF,
    parameter int TRRC  = TRRC_DEF,
    parameter int TRCD  = TRCD_DEF,
    parameter int CL    = CL_DEF,
    parameter int TWR   = TWR_DEF,
    parameter int TMRD  = TMRD_DEF
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [3:0]  iCall,
    output logic        oDone,
    input  logic [23:0] iAddr,
    input  logic [15:0] iData,
    output logic [15:0] oData,
    output logic        S_CKE,
    output logic        S_NCS,
    output logic        S_NRAS,
    output logic        S_NCAS,
    output logic        S_NWE,
    output logic [1:0]  S_BA,
    output logic [12:0] S_A,
    output logic [1:0]  S_DQM,
    inout  wire  [15:0] S_DQ
);

    state_e           state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [1:0]       ba_q, ba_d;
    logic [12:0]      a_q, a_d;
    logic             dq_oe_q, dq_oe_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [1:0]       bank_q, bank_d;
    logic [8:0]       col_q, col_d;
    logic             is_init_q, is_init_d;
    logic             is_write_q, is_write_d;
    logic             done_q, done_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_expire;

    sdram_wait_counter u_wait (
        .clk      (CLOCK),
        .rst_n    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .expire   (cnt_expire)
    );

    // Next-state, next-pin and step-length decode
    always_comb begin
        state_d    = state_q;
        cmd_d      = CMD_NOP;
        ba_d       = ba_q;
        a_d        = a_q;
        dq_oe_d    = 1'b0;
        wdata_d    = wdata_q;
        bank_d     = bank_q;
        col_d      = col_q;
        is_init_d  = is_init_q;
        is_write_d = is_write_q;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state_q)
            ST_IDLE: begin
                if (iCall[CALL_INIT]) begin
                    state_d   = ST_INIT_WAIT;
                    is_init_d = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(TINIT);
                end else if (iCall[CALL_REFRESH]) begin
                    state_d   = ST_PRE;
                    is_init_d = 1'b0;
                    cmd_d     = CMD_PRE;
                    a_d       = A10_ALL;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(TRP);
                end else if (iCall[CALL_WRITE] || iCall[CALL_READ]) begin
                    state_d    = ST_ACT;
                    is_init_d  = 1'b0;
                    is_write_d = iCall[CALL_WRITE];
                    bank_d     = iAddr[23:22];
                    col_d      = iAddr[8:0];
                    wdata_d    = iData;
                    cmd_d      = CMD_ACT;
                    ba_d       = iAddr[23:22];
                    a_d        = iAddr[21:9];
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(TRCD);
                end
            end
            ST_INIT_WAIT: begin
                if (cnt_expire) begin
                    state_d  = ST_PRE;
                    cmd_d    = CMD_PRE;
                    a_d      = A10_ALL;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TRP);
                end
            end
            ST_PRE: begin
                if (cnt_expire) begin
                    state_d  = ST_AREF1;
                    cmd_d    = CMD_AREF;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TRRC);
                end
            end
            ST_AREF1: begin
                if (cnt_expire) begin
                    cnt_load = 1'b1;
                    if (is_init_q) begin
                        state_d = ST_AREF2;
                        cmd_d   = CMD_AREF;
                        cnt_val = CNT_W'(TRRC);
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        cnt_val = CNT_W'(1);
                    end
                end
            end
            ST_AREF2: begin
                if (cnt_expire) begin
                    state_d  = ST_LMR;
                    cmd_d    = CMD_LMR;
                    ba_d     = 2'b00;
                    a_d      = MODE_REG;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TMRD);
                end
            end
            ST_LMR: begin
                if (cnt_expire) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(1);
                end
            end
            ST_ACT: begin
                if (cnt_expire) begin
                    state_d  = ST_RW;
                    cmd_d    = is_write_q ? CMD_WRITE : CMD_READ;
                    ba_d     = bank_q;
                    a_d      = {3'b001, 1'b0, col_q};
                    dq_oe_d  = is_write_q;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(1);
                end
            end
            ST_RW: begin
                // Write: recovery plus auto-precharge; read: wait out CAS latency
                state_d  = ST_WAIT;
                cnt_load = 1'b1;
                cnt_val  = is_write_q ? CNT_W'(TWR + TRP - 1) : CNT_W'(CL);
            end
            ST_WAIT: begin
                if (cnt_expire) begin
                    if (!is_write_q) begin
                        rdata_d = S_DQ;
                    end
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE_WAIT;
            end
            ST_DONE_WAIT: begin
                // Hold off until the caller drops its request
                if (iCall == 4'b0000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered pin outputs
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'b00;
            a_q        <= 13'h0000;
            dq_oe_q    <= 1'b0;
            wdata_q    <= 16'h0000;
            bank_q     <= 2'b00;
            col_q      <= 9'h000;
            is_init_q  <= 1'b0;
            is_write_q <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            a_q        <= a_d;
            dq_oe_q    <= dq_oe_d;
            wdata_q    <= wdata_d;
            bank_q     <= bank_d;
            col_q      <= col_d;
            is_init_q  <= is_init_d;
            is_write_q <= is_write_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
        end
    end

    assign {S_NRAS, S_NCAS, S_NWE} = cmd_q;
    assign S_CKE = 1'b1;
    assign S_NCS = 1'b0;
    assign S_DQM = 2'b00;
    assign S_BA  = ba_q;
    assign S_A   = a_q;
    assign S_DQ  = dq_oe_q ? wdata_q : 16'hzzzz;
    assign oDone = done_q;
    assign oData = rdata_q;

endmodule

// File: tb/tb_sdram_funcmod.sv
// Bench for sdram_funcmod: table of directed operations, a reset-abort
// sequence and randomized write/read/refresh traffic against a timing model.
module tb_sdram_funcmod;

    localparam int TINIT = 20;
    localparam int TRP   = 3;
    localparam int TRRC  = 9;
    localparam int TRCD  = 3;
    localparam int CL    = 3;
    localparam int TWR   = 2;
    localparam int TMRD  = 2;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                           C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    localparam int OP_INIT = 0, OP_REF = 1, OP_WR = 2, OP_RD = 3;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [3:0]  iCall;
    logic        oDone;
    logic [23:0] iAddr;
    logic [15:0] iData;
    logic [15:0] oData;
    logic        S_CKE, S_NCS, S_NRAS, S_NCAS, S_NWE;
    logic [1:0]  S_BA;
    logic [12:0] S_A;
    logic [1:0]  S_DQM;
    wire  [15:0] S_DQ;
    logic [15:0] tb_dq;
    logic        tb_dq_oe;

    int n_tests = 0;
    int n_fail  = 0;

    assign S_DQ = tb_dq_oe ? tb_dq : 16'hzzzz;

    always #5 CLOCK = ~CLOCK;

    sdram_funcmod #(
        .TINIT(TINIT), .TRP(TRP), .TRRC(TRRC), .TRCD(TRCD), .CL(CL), .TWR(TWR), .TMRD(TMRD)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall), .oDone(oDone), .iAddr(iAddr),
        .iData(iData), .oData(oData), .S_CKE(S_CKE), .S_NCS(S_NCS), .S_NRAS(S_NRAS),
        .S_NCAS(S_NCAS), .S_NWE(S_NWE), .S_BA(S_BA), .S_A(S_A), .S_DQM(S_DQM), .S_DQ(S_DQ)
    );

    typedef struct {
        logic [3:0]  call;
        logic [23:0] addr;
        logic [15:0] data;
        logic [15:0] rdval;      // value the bus model returns; expected oData
        int          hold;       // cycles iCall stays high after the done cycle
        bit          drop_early; // drop iCall right after acceptance
        int          exp_op;
        int          exp_done;   // expected oDone offset from first command cycle
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Completion offset derived from the timing rules
    function automatic int done_off(input int op);
        case (op)
            OP_INIT: return TINIT + TRP + 2 * TRRC + TMRD;
            OP_REF:  return TRP + TRRC;
            OP_WR:   return TRCD + TWR + TRP;
            default: return TRCD + CL + 1;
        endcase
    endfunction

    // Command expected on the pins k cycles after acceptance
    function automatic logic [2:0] exp_cmd(input int op, input int k);
        case (op)
            OP_INIT: begin
                if (k == TINIT) return C_PRE;
                if (k == TINIT + TRP || k == TINIT + TRP + TRRC) return C_REF;
                if (k == TINIT + TRP + 2 * TRRC) return C_LMR;
            end
            OP_REF: begin
                if (k == 0) return C_PRE;
                if (k == TRP) return C_REF;
            end
            OP_WR: begin
                if (k == 0) return C_ACT;
                if (k == TRCD) return C_WR;
            end
            default: begin
                if (k == 0) return C_ACT;
                if (k == TRCD) return C_RD;
            end
        endcase
        return C_NOP;
    endfunction

    task automatic run_op(input vec_t v, input int d, input string tag);
        logic [2:0] ec;
        @(negedge CLOCK);
        iCall = v.call;
        iAddr = v.addr;
        iData = v.data;
        @(posedge CLOCK);
        for (int k = 0; k <= d + v.hold + 4; k++) begin
            @(negedge CLOCK);
            ec = exp_cmd(v.exp_op, k);
            check($sformatf("%s cmd@%0d", tag, k), {29'd0, S_NRAS, S_NCAS, S_NWE}, {29'd0, ec});
            check($sformatf("%s done@%0d", tag, k), {31'd0, oDone}, {31'd0, (k == d)});
            if (ec == C_ACT)
                check($sformatf("%s act_addr", tag), {17'd0, S_BA, S_A}, {17'd0, v.addr[23:22], v.addr[21:9]});
            if (ec == C_WR || ec == C_RD)
                check($sformatf("%s col_addr", tag), {17'd0, S_BA, S_A},
                      {17'd0, v.addr[23:22], 4'b0010, v.addr[8:0]});
            if (ec == C_WR)
                check($sformatf("%s wr_dq", tag), {16'd0, S_DQ}, {16'd0, v.data});
            if (ec == C_PRE)
                check($sformatf("%s pre_a10", tag), {31'd0, S_A[10]}, 32'd1);
            if (ec == C_LMR)
                check($sformatf("%s lmr_mode", tag), {17'd0, S_BA, S_A}, {17'd0, 2'b00, 13'h030});
            if (k == d && v.exp_op == OP_RD)
                check($sformatf("%s odata", tag), {16'd0, oData}, {16'd0, v.rdval});
            // Disturb inputs after acceptance; the latched copies must be used
            if (k == 0) begin
                iAddr = 24'($urandom);
                iData = 16'($urandom);
                if (v.drop_early) iCall = 4'b0000;
            end
            if (k == d + v.hold) iCall = 4'b0000;
            // Bus model: wrong data before the capture edge, correct data for it
            tb_dq_oe = 1'b0;
            if (v.exp_op == OP_RD && k == TRCD + CL) begin
                tb_dq_oe = 1'b1;
                tb_dq    = v.rdval;
            end else if (v.exp_op == OP_RD && (k == TRCD + CL - 1 || k == TRCD + CL - 2)) begin
                tb_dq_oe = 1'b1;
                tb_dq    = ~v.rdval;
            end
        end
        tb_dq_oe = 1'b0;
        iCall    = 4'b0000;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, " cmd"},  {29'd0, S_NRAS, S_NCAS, S_NWE}, {29'd0, C_NOP});
        check({tag, " done"}, {31'd0, oDone}, 32'd0);
        check({tag, " odata"}, {16'd0, oData}, 32'd0);
        check({tag, " ba_a"}, {17'd0, S_BA, S_A}, 32'd0);
        check({tag, " cke_ncs_dqm"}, {28'd0, S_CKE, S_NCS, S_DQM}, {28'd0, 4'b1000});
    endtask

    vec_t vecs[6];
    logic [15:0] mem [logic [23:0]];
    logic [23:0] pool [4];

    initial begin
        RESET    = 1'b0;
        iCall    = 4'b0000;
        iAddr    = 24'd0;
        iData    = 16'd0;
        tb_dq    = 16'd0;
        tb_dq_oe = 1'b0;

        vecs[0] = '{4'b0001, 24'h000000, 16'h0000, 16'h0000, 1, 0, OP_INIT, 43};
        vecs[1] = '{4'b1000, 24'hC12345, 16'hA55A, 16'h0000, 1, 0, OP_WR,   8};
        vecs[2] = '{4'b0100, 24'hC12345, 16'h0000, 16'h1234, 1, 0, OP_RD,   7};
        vecs[3] = '{4'b0010, 24'h000000, 16'h0000, 16'h0000, 1, 0, OP_REF,  12};
        vecs[4] = '{4'b1110, 24'h7FFFFF, 16'h0000, 16'h0000, 3, 0, OP_REF,  12};
        vecs[5] = '{4'b1100, 24'h3FFE00, 16'hFFFF, 16'h0000, 0, 1, OP_WR,   8};

        repeat (3) @(negedge CLOCK);
        check_reset_pins("reset");
        RESET = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i], vecs[i].exp_done, $sformatf("vec%0d", i));

        // Reset pulled during a write, two cycles after ACT
        @(negedge CLOCK);
        iCall = 4'b1000;
        iAddr = 24'h812345;
        iData = 16'h5AA5;
        @(posedge CLOCK);
        @(negedge CLOCK);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        check_reset_pins("rst_mid");
        iCall = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK);
            check($sformatf("rst_hold cmd@%0d", k), {29'd0, S_NRAS, S_NCAS, S_NWE}, {29'd0, C_NOP});
            check($sformatf("rst_hold done@%0d", k), {31'd0, oDone}, 32'd0);
        end
        RESET = 1'b1;
        run_op('{4'b0100, 24'h812345, 16'h0000, 16'hBEEF, 0, 0, OP_RD, 7}, 7, "post_rst_rd");

        // Randomized traffic over a small address pool so reads hit earlier writes
        for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
        for (int i = 0; i < 24; i++) begin
            vec_t r;
            int   op;
            op           = int'($urandom_range(1, 3));
            r.addr       = pool[$urandom_range(0, 3)];
            r.data       = 16'($urandom);
            r.hold       = int'($urandom_range(0, 3));
            r.drop_early = 1'($urandom);
            r.exp_op     = op;
            r.rdval      = 16'($urandom);
            case (op)
                OP_REF: r.call = {2'($urandom), 2'b10};
                OP_WR:  r.call = {1'b1, 1'($urandom), 2'b00};
                default: begin
                    r.call = 4'b0100;
                    if (mem.exists(r.addr)) r.rdval = mem[r.addr];
                end
            endcase
            r.exp_done = done_off(op);
            if (op == OP_WR) mem[r.addr] = r.data;
            run_op(r, r.exp_done, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
